led_seq_ctrl: RTL and testbench

//  Sequencer for the board LED bar: owns the tick prescaler and the 4-LED pattern register.

---
 rtl/led_seq_pkg.sv | 23 ++
 rtl/led_seq_if.sv | 10 +
 rtl/led_seq_tick.sv | 34 +++
 rtl/led_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_led_seq_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared mode/direction types and pattern constants for the LED sequencer
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_BWD = 1'b1
  } dir_e;

  localparam logic [3:0] RESET_PATTERN = 4'b0001;
  localparam logic [3:0] BLINK_PATTERN = 4'b1111;

  function automatic logic [3:0] start_pattern(mode_e m);
    return (m == MODE_BLINK) ? BLINK_PATTERN : RESET_PATTERN;
  endfunction

endpackage

// File: rtl/led_seq_if.sv
// rtl/led_seq_if.sv - valid/ready command bundle carrying {mode, rate} from host to sequencer
interface led_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [1:0] cmd_rate;

  modport master (output cmd_valid, output cmd_mode, output cmd_rate, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_mode, input cmd_rate, output cmd_ready);
endinterface

// File: rtl/led_seq_tick.sv
// rtl/led_seq_tick.sv - variable-modulo prescaler; wrap pulses once every BASE_DIV<<rate cycles
module led_seq_tick #(
  parameter int BASE_DIV = 4
) (
  input  logic       sysclk,
  input  logic       resetn,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] rate,
  output logic       wrap
);

  localparam int CW = $clog2(BASE_DIV << 3);

  logic [CW-1:0] cnt;
  logic [CW-1:0] last;

  always_comb begin
    last = CW'((BASE_DIV << rate) - 1);
    wrap = en && (cnt == last);
  end

  // Held at zero while disabled so a freshly enabled mode always gets a full first period.
  always_ff @(posedge sysclk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr || !en || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - LED bar sequencer: command handshake, pending command, mode FSM, pattern
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int CLOCK_FREQ = 12000000,
  parameter int TICK_HZ    = 10
) (
  input  logic         sysclk,
  input  logic         resetn,
  led_seq_if.slave     cmd,
  output logic [4:0]   led,
  output logic         step,
  output logic [7:0]   debug
);

  localparam int BASE_DIV = CLOCK_FREQ / TICK_HZ;

  mode_e      mode_q, mode_d;
  logic [1:0] rate_q, rate_d;
  logic       pend_valid_q, pend_valid_d;
  mode_e      pend_mode_q, pend_mode_d;
  logic [1:0] pend_rate_q, pend_rate_d;
  logic [3:0] bar_q, bar_d;
  dir_e       dir_q, dir_d;
  logic       ready_q, ready_d;
  logic [4:0] led_d;
  logic       step_d;
  logic [7:0] debug_d;

  logic       tick_en;
  logic       wrap;
  logic       accept;
  logic       apply;

  assign cmd.cmd_ready = ready_q;
  assign tick_en       = (mode_q != MODE_OFF);

  led_seq_tick #(
    .BASE_DIV (BASE_DIV)
  ) u_tick (
    .sysclk (sysclk),
    .resetn (resetn),
    .en     (tick_en),
    .clr    (apply),
    .rate   (rate_q),
    .wrap   (wrap)
  );

  always_comb begin
    mode_d       = mode_q;
    rate_d       = rate_q;
    pend_valid_d = pend_valid_q;
    pend_mode_d  = pend_mode_q;
    pend_rate_d  = pend_rate_q;
    bar_d        = bar_q;
    dir_d        = dir_q;
    step_d       = 1'b0;

    accept = cmd.cmd_valid && ready_q;
    // An idle sequencer has no wrap to wait for, so a pending command lands immediately.
    apply  = pend_valid_q && ((mode_q == MODE_OFF) || wrap);

    if (apply) begin
      mode_d       = pend_mode_q;
      rate_d       = pend_rate_q;
      pend_valid_d = 1'b0;
      bar_d        = start_pattern(pend_mode_q);
      dir_d        = DIR_FWD;
    end else if (wrap) begin
      step_d = 1'b1;
      unique case (mode_q)
        MODE_BOUNCE: begin
          if (dir_q == DIR_FWD) begin
            if (bar_q[3]) begin
              bar_d = 4'b0100;
              dir_d = DIR_BWD;
            end else begin
              bar_d = bar_q << 1;
            end
          end else begin
            if (bar_q[0]) begin
              bar_d = 4'b0010;
              dir_d = DIR_FWD;
            end else begin
              bar_d = bar_q >> 1;
            end
          end
        end
        MODE_CHASE: bar_d = {bar_q[2:0], bar_q[3]};
        MODE_BLINK: bar_d = ~bar_q;
        default:    bar_d = bar_q;
      endcase
    end

    // accept and apply are exclusive: accept needs ready, apply needs a pending command.
    if (accept) begin
      pend_valid_d = 1'b1;
      pend_mode_d  = mode_e'(cmd.cmd_mode);
      pend_rate_d  = cmd.cmd_rate;
    end

    ready_d = ~pend_valid_d;
    led_d   = (mode_d != MODE_OFF) ? {1'b1, bar_d} : 5'b0;
    debug_d = {mode_d, rate_d, pend_valid_d, dir_d, step_d, ready_d};
  end

  always_ff @(posedge sysclk or negedge resetn) begin
    if (!resetn) begin
      mode_q       <= MODE_OFF;
      rate_q       <= 2'd0;
      pend_valid_q <= 1'b0;
      pend_mode_q  <= MODE_OFF;
      pend_rate_q  <= 2'd0;
      bar_q        <= RESET_PATTERN;
      dir_q        <= DIR_FWD;
      ready_q      <= 1'b1;
      led          <= 5'b0;
      step         <= 1'b0;
      debug        <= 8'h01;
    end else begin
      mode_q       <= mode_d;
      rate_q       <= rate_d;
      pend_valid_q <= pend_valid_d;
      pend_mode_q  <= pend_mode_d;
      pend_rate_q  <= pend_rate_d;
      bar_q        <= bar_d;
      dir_q        <= dir_d;
      ready_q      <= ready_d;
      led          <= led_d;
      step         <= step_d;
      debug        <= debug_d;
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - scoreboard bench for led_seq_ctrl with BASE_DIV=4
module tb_led_seq_ctrl;

  logic       sysclk;
  logic       resetn;
  logic [4:0] led;
  logic       step;
  logic [7:0] debug;

  led_seq_if cmd_if ();

  led_seq_ctrl #(
    .CLOCK_FREQ (40),
    .TICK_HZ    (10)
  ) dut (
    .sysclk (sysclk),
    .resetn (resetn),
    .cmd    (cmd_if),
    .led    (led),
    .step   (step),
    .debug  (debug)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int edge_cnt = 0;
  always @(posedge sysclk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int         at_edge;
    logic [4:0] led;
    logic [3:0] dbg_hi;
    bit         is_step;
  } ev_t;

  ev_t exp_q[$];
  ev_t ev;
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  prev_ready = 1'b1;
  bit  rose;

  // Model: active pattern began at edge m_a, steps every m_p edges; m_j = last step index queued.
  int m_mode = 0;
  int m_rate = 0;
  int m_a    = 0;
  int m_p    = 4;
  int m_j    = 0;
  int ap_prev = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic logic [3:0] pat(input int m, input int j);
    logic [3:0] bounce[6];
    logic [3:0] one;
    bounce = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};
    one    = 4'b0001;
    case (m)
      1:       return bounce[j % 6];
      2:       return one << (j % 4);
      3:       return ((j % 2) == 0) ? 4'b1111 : 4'b0000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [4:0] exp_led(input int m, input int j);
    if (m == 0) return 5'b0;
    return {1'b1, pat(m, j)};
  endfunction

  task automatic push_steps(input int lim);
    ev_t e;
    if (m_mode != 0) begin
      while (m_a + (m_j + 1) * m_p < lim) begin
        m_j++;
        e.at_edge = m_a + m_j * m_p;
        e.led     = exp_led(m_mode, m_j);
        e.dbg_hi  = {m_mode[1:0], m_rate[1:0]};
        e.is_step = 1'b1;
        exp_q.push_back(e);
      end
    end
  endtask

  // kind 0: accept after gap; kind 1: accept exactly on a wrap edge; kind 2: hold valid while pending
  task automatic issue(input int md, input int rt, input int kind, input int gap);
    int  earliest, c, ap, k, t;
    ev_t e;
    earliest = (ap_prev + 1 > edge_cnt + 1) ? ap_prev + 1 : edge_cnt + 1;
    if (kind == 2) begin
      c = earliest;
    end else if (kind == 1 && m_mode != 0) begin
      t = earliest + gap;
      k = (t - m_a + m_p - 1) / m_p;
      if (k < 1) k = 1;
      c = m_a + k * m_p;
    end else begin
      c = earliest + gap;
    end
    ap = (m_mode == 0) ? c + 1 : m_a + ((c - m_a) / m_p + 1) * m_p;
    push_steps(ap);
    m_mode  = md;
    m_rate  = rt;
    m_a     = ap;
    m_p     = 4 << rt;
    m_j     = 0;
    ap_prev = ap;
    e.at_edge = ap;
    e.led     = exp_led(md, 0);
    e.dbg_hi  = {md[1:0], rt[1:0]};
    e.is_step = 1'b0;
    exp_q.push_back(e);

    if (kind == 2) begin
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_mode  = md[1:0];
      cmd_if.cmd_rate  = rt[1:0];
      while (edge_cnt < c) @(negedge sysclk);
    end else begin
      while (edge_cnt < c - 1) @(negedge sysclk);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_mode  = md[1:0];
      cmd_if.cmd_rate  = rt[1:0];
      @(negedge sysclk);
    end
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_mode  = 2'($urandom);
    cmd_if.cmd_rate  = 2'($urandom);
  endtask

  always @(negedge sysclk) begin
    if (resetn) begin
      rose = cmd_if.cmd_ready && !prev_ready;
      if (step || rose) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: edge %0d led %b step %b, expected no event", edge_cnt, led, step);
        end else begin
          ev = exp_q.pop_front();
          chk("ev_edge", edge_cnt, ev.at_edge);
          chk("ev_is_step", step, ev.is_step);
          chk("ev_led", led, ev.led);
          chk("ev_mode_rate", debug[7:4], ev.dbg_hi);
        end
      end
    end
    prev_ready = cmd_if.cmd_ready;
  end

  initial begin
    int md, rt, kind, gap;
    resetn           = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_mode  = 2'd0;
    cmd_if.cmd_rate  = 2'd0;
    @(negedge sysclk);
    #2;
    chk("rst_led", led, 5'b0);
    chk("rst_step", step, 1'b0);
    chk("rst_ready", cmd_if.cmd_ready, 1'b1);
    chk("rst_debug", debug, 8'h01);
    @(negedge sysclk);
    resetn = 1'b1;

    issue(1, 0, 0, 2);
    issue(2, 2, 0, 30);
    issue(1, 0, 0, 70);
    issue(3, 0, 0, 9);
    issue(2, 0, 2, 0);
    issue(1, 1, 1, 10);
    issue(1, 1, 0, 5);
    issue(0, 0, 0, 6);
    issue(0, 0, 0, 3);

    for (int i = 0; i < 24; i++) begin
      md   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
      rt   = $urandom_range(0, 3);
      kind = $urandom_range(0, 2);
      gap  = $urandom_range(0, 40);
      issue(md, rt, kind, gap);
    end

    issue(1, 0, 0, 3);
    push_steps(ap_prev + 11);
    while (edge_cnt < ap_prev + 10) @(negedge sysclk);
    chk("pre_reset_drained", exp_q.size(), 0);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_led", led, 5'b0);
    chk("async_rst_step", step, 1'b0);
    chk("async_rst_ready", cmd_if.cmd_ready, 1'b1);
    chk("async_rst_debug", debug, 8'h01);
    exp_q.delete();
    m_mode  = 0;
    m_rate  = 0;
    m_j     = 0;
    ap_prev = 0;
    repeat (2) @(negedge sysclk);
    resetn = 1'b1;

    issue(1, 1, 0, 0);
    issue(0, 0, 0, 20);
    while (edge_cnt < ap_prev + 3) @(negedge sysclk);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
